// File: rtl/led_pwm_bank_pkg.sv
// Shared types for the LED PWM bank: MODE layout, LEDOUT codes and register map helpers.
package led_pwm_bank_pkg;

  typedef struct packed {
    logic [2:0] auto_inc;
    logic       sleep;
    logic       dim_blink;
    logic       invert;
    logic       output_change;
    logic       reserved;
  } reg_mode_t;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_PWM   = 2'd2,
    LED_GROUP = 2'd3
  } led_out_enum_t;

  typedef struct packed {
    logic [7:0] grppwm;
    logic [7:0] grpfreq;
    logic [7:0] ledout0;
  } reg_index_t;

  localparam logic [7:0] MODE_RESET = 8'h10;

  function automatic reg_index_t reg_index(input int num_leds);
    reg_index_t r;
    r.grppwm  = 8'(num_leds + 1);
    r.grpfreq = 8'(num_leds + 2);
    r.ledout0 = 8'(num_leds + 3);
    return r;
  endfunction

endpackage

// File: rtl/led_pwm_bank_timebase.sv
// PWM timebase: prescaler, fast counter (PWM ramp) and blink counter, all held at zero in sleep.
module led_pwm_bank_timebase #(
  parameter int DATA_BITS = 8,
  parameter int PRESCALE  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sleep_i,
  input  logic [DATA_BITS-1:0] grpfreq_i,
  output logic [DATA_BITS-1:0] fcnt_o,
  output logic [DATA_BITS-1:0] bcnt_o,
  output logic                 period_end_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]        presc_q, presc_d;
  logic [DATA_BITS-1:0] fcnt_q, fcnt_d;
  logic [DATA_BITS-1:0] fwc_q, fwc_d;
  logic [DATA_BITS-1:0] bcnt_q, bcnt_d;
  logic                 presc_wrap, fcnt_wrap;

  assign presc_wrap = (presc_q == PW'(PRESCALE - 1));
  assign fcnt_wrap  = presc_wrap && (fcnt_q == '1);

  // fwc counts fcnt wraps; >= keeps it from running away if GRPFREQ shrinks mid-count
  always_comb begin
    presc_d = presc_q;
    fcnt_d  = fcnt_q;
    fwc_d   = fwc_q;
    bcnt_d  = bcnt_q;
    if (sleep_i) begin
      presc_d = '0;
      fcnt_d  = '0;
      fwc_d   = '0;
      bcnt_d  = '0;
    end else begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;
      if (presc_wrap) fcnt_d = fcnt_q + 1'b1;
      if (fcnt_wrap) begin
        if (fwc_q >= grpfreq_i) begin
          fwc_d  = '0;
          bcnt_d = bcnt_q + 1'b1;
        end else begin
          fwc_d = fwc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      fcnt_q  <= '0;
      fwc_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      fcnt_q  <= fcnt_d;
      fwc_q   <= fwc_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign fcnt_o       = fcnt_q;
  assign bcnt_o       = bcnt_q;
  assign period_end_o = fcnt_wrap && !sleep_i;

endmodule

// File: rtl/led_pwm_bank.sv
// N-channel LED driver core: staged/active register file, duty latch and registered output stage.
module led_pwm_bank
  import led_pwm_bank_pkg::*;
#(
  parameter int NUM_LEDS  = 4,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 3,
  parameter int PRESCALE  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sleep_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 w_en_i,
  input  logic                 r_en_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o,
  input  logic                 i2c_stop_i,
  output logic [NUM_LEDS-1:0]  led_out_o
);

  localparam reg_index_t IDX = reg_index(NUM_LEDS);
  localparam int NREG = NUM_LEDS + 3 + (NUM_LEDS + 3) / 4;
  localparam int IW   = $clog2(NREG);

  typedef logic [DATA_BITS-1:0] data_t;

  function automatic data_t rst_val(input int k);
    if (k == 0) return data_t'(MODE_RESET);
    if (k == int'(IDX.grppwm)) return '1;
    return '0;
  endfunction

  // Entry 0 of the staged array is MODE itself; it has no active/latched copy
  data_t stg_q [NREG];
  data_t stg_d [NREG];
  data_t act_q [1:NREG-1];
  data_t lat_q [1:NREG-1];
  data_t rdata_q;

  logic [IW-1:0]       a_idx;
  logic                mapped, commit, sleep, period_end;
  reg_mode_t           mode;
  data_t               fcnt, bcnt;
  logic [NUM_LEDS-1:0] raw, led_d, led_q;

  assign a_idx  = IW'(addr_i);
  assign mapped = int'(addr_i) < NREG;
  assign mode   = reg_mode_t'(stg_q[0][7:0]);
  assign sleep  = mode.sleep | sleep_i;
  assign commit = mode.output_change ? (w_en_i && mapped && (a_idx != '0)) : i2c_stop_i;

  always_comb begin
    stg_d = stg_q;
    if (w_en_i && mapped) begin
      stg_d[a_idx] = (a_idx == '0) ? (wdata_i & ~data_t'(1)) : wdata_i;
    end
  end

  // Commit takes stg_d so a byte written alongside the commit event is included
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NREG; k++) stg_q[k] <= rst_val(k);
      for (int k = 1; k < NREG; k++) begin
        act_q[k] <= rst_val(k);
        lat_q[k] <= rst_val(k);
      end
      rdata_q <= '0;
    end else begin
      stg_q <= stg_d;
      if (commit) begin
        for (int k = 1; k < NREG; k++) act_q[k] <= stg_d[k];
      end
      if (sleep || period_end) begin
        for (int k = 1; k < NREG; k++) lat_q[k] <= act_q[k];
      end
      if (r_en_i && !w_en_i) rdata_q <= mapped ? stg_q[a_idx] : '0;
    end
  end

  led_pwm_bank_timebase #(
    .DATA_BITS (DATA_BITS),
    .PRESCALE  (PRESCALE)
  ) u_timebase (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .sleep_i      (sleep),
    .grpfreq_i    (act_q[IDX.grpfreq]),
    .fcnt_o       (fcnt),
    .bcnt_o       (bcnt),
    .period_end_o (period_end)
  );

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    localparam int LO = int'(IDX.ledout0) + i / 4;
    led_out_enum_t code;
    logic          pwm_hit, grp_hit;
    assign code    = led_out_enum_t'(lat_q[LO][2*(i%4) +: 2]);
    assign pwm_hit = fcnt < lat_q[i+1];
    assign grp_hit = (mode.dim_blink ? bcnt : fcnt) < lat_q[IDX.grppwm];
    assign raw[i]  = (code == LED_ON)
                   | ((code == LED_PWM) & pwm_hit)
                   | ((code == LED_GROUP) & pwm_hit & grp_hit);
  end

  assign led_d = sleep ? {NUM_LEDS{mode.invert}} : (raw ^ {NUM_LEDS{mode.invert}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) led_q <= '0;
    else         led_q <= led_d;
  end

  assign rdata_o   = rdata_q;
  assign led_out_o = led_q;

endmodule
